// File: rtl/game_flow_controller.sv
// Breakout game sequencer: phase FSM, lives/level bookkeeping and
// per-frame update trigger for the game logic.
module game_flow_controller #(
  parameter int unsigned INITIAL_LIVES      = 3,
  parameter int unsigned SERVE_ARM_FRAMES   = 30,
  parameter int unsigned LOST_DELAY_FRAMES  = 90,
  parameter int unsigned CLEAR_DELAY_FRAMES = 120,
  parameter int unsigned MAX_LEVEL          = 15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       FRAME_START,
  input  logic       BTN_FIRE,
  input  logic       BTN_PAUSE,
  input  logic       BALL_LOST,
  input  logic       BRICKS_CLEARED,
  output logic       START_UPDATE,
  output logic       BALL_HOLD,
  output logic       BALL_RESET,
  output logic       LEVEL_NEXT,
  output logic [2:0] LIVES,
  output logic [3:0] LEVEL,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_ATTRACT   = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSED    = 3'd3,
    S_LOST      = 3'd4,
    S_CLEAR     = 3'd5,
    S_GAME_OVER = 3'd6
  } state_t;

  localparam logic [7:0] ARM_F   = 8'(SERVE_ARM_FRAMES);
  localparam logic [7:0] LOST_F  = 8'(LOST_DELAY_FRAMES);
  localparam logic [7:0] CLEAR_F = 8'(CLEAR_DELAY_FRAMES);
  localparam logic [3:0] MAX_L   = 4'(MAX_LEVEL);
  localparam logic [2:0] INIT_L  = 3'(INITIAL_LIVES);

  state_t     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [3:0] level_q, level_d;
  logic [7:0] timer_q;
  logic       fire_q, pause_q, armed_q;
  logic       fire_edge, pause_edge;
  logic       ball_reset_d, level_next_d;

  // armed_q blocks edges in the first cycle after reset so a held
  // button is only seen as a level, never as a fresh press.
  assign fire_edge  = armed_q & BTN_FIRE & ~fire_q;
  assign pause_edge = armed_q & BTN_PAUSE & ~pause_q;

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    level_d      = level_q;
    ball_reset_d = 1'b0;
    level_next_d = 1'b0;
    unique case (state_q)
      S_ATTRACT, S_GAME_OVER: begin
        if (fire_edge) begin
          state_d      = S_SERVE;
          lives_d      = INIT_L;
          level_d      = 4'd0;
          ball_reset_d = 1'b1;
          level_next_d = 1'b1;
        end
      end
      S_SERVE: begin
        if (fire_edge && timer_q >= ARM_F)
          state_d = S_PLAY;
      end
      S_PLAY: begin
        if (BALL_LOST) begin
          if (lives_q <= 3'd1) begin
            lives_d = 3'd0;
            state_d = S_GAME_OVER;
          end else begin
            lives_d = lives_q - 3'd1;
            state_d = S_LOST;
          end
        end else if (BRICKS_CLEARED) begin
          state_d = S_CLEAR;
        end else if (pause_edge) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause_edge)
          state_d = S_PLAY;
      end
      S_LOST: begin
        if (timer_q >= LOST_F) begin
          state_d      = S_SERVE;
          ball_reset_d = 1'b1;
        end
      end
      S_CLEAR: begin
        if (timer_q >= CLEAR_F) begin
          state_d      = S_SERVE;
          ball_reset_d = 1'b1;
          level_next_d = 1'b1;
          level_d      = (level_q >= MAX_L) ? MAX_L
                                            : level_q + 4'd1;
        end
      end
      default: state_d = S_ATTRACT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_ATTRACT;
      lives_q      <= 3'd0;
      level_q      <= 4'd0;
      timer_q      <= 8'd0;
      fire_q       <= 1'b0;
      pause_q      <= 1'b0;
      armed_q      <= 1'b0;
      START_UPDATE <= 1'b0;
      BALL_HOLD    <= 1'b1;
      BALL_RESET   <= 1'b0;
      LEVEL_NEXT   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      fire_q       <= BTN_FIRE;
      pause_q      <= BTN_PAUSE;
      armed_q      <= 1'b1;
      BALL_RESET   <= ball_reset_d;
      LEVEL_NEXT   <= level_next_d;
      BALL_HOLD    <= (state_d != S_PLAY);
      START_UPDATE <= FRAME_START &
                      (state_q == S_SERVE || state_q == S_PLAY);
      if (state_d != state_q)
        timer_q <= 8'd0;
      else if (FRAME_START && timer_q != 8'hFF)
        timer_q <= timer_q + 8'd1;
    end
  end

  assign LIVES = lives_q;
  assign LEVEL = level_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: scripted game flow with a
// START_UPDATE scoreboard keyed on the expected cycle.
module tb_game_flow_controller;

  logic       CLK = 1'b0;
  logic       RESET, FRAME_START, BTN_FIRE, BTN_PAUSE;
  logic       BALL_LOST, BRICKS_CLEARED;
  logic       START_UPDATE, BALL_HOLD, BALL_RESET, LEVEL_NEXT;
  logic [2:0] LIVES, STATE;
  logic [3:0] LEVEL;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int br_cnt  = 0;
  int ln_cnt  = 0;
  int br0, ln0;
  bit exp_run = 0;
  int su_q[$];

  game_flow_controller dut (
    .CLK(CLK), .RESET(RESET), .FRAME_START(FRAME_START),
    .BTN_FIRE(BTN_FIRE), .BTN_PAUSE(BTN_PAUSE),
    .BALL_LOST(BALL_LOST), .BRICKS_CLEARED(BRICKS_CLEARED),
    .START_UPDATE(START_UPDATE), .BALL_HOLD(BALL_HOLD),
    .BALL_RESET(BALL_RESET), .LEVEL_NEXT(LEVEL_NEXT),
    .LIVES(LIVES), .LEVEL(LEVEL), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (BALL_RESET) br_cnt++;
    if (LEVEL_NEXT) ln_cnt++;
    if (START_UPDATE) begin
      if (su_q.size() == 0) check("su_extra", cyc, -1);
      else check("su_cycle", cyc, su_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic frame();
    FRAME_START = 1'b1;
    if (exp_run) su_q.push_back(cyc + 1);
    tick();
    FRAME_START = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic fire();
    BTN_FIRE = 1'b1;
    tick();
    BTN_FIRE = 1'b0;
    tick();
  endtask

  task automatic pause();
    BTN_PAUSE = 1'b1;
    tick();
    BTN_PAUSE = 1'b0;
    tick();
  endtask

  task automatic pulse(input bit lost, input bit clr);
    BALL_LOST      = lost;
    BRICKS_CLEARED = clr;
    tick();
    BALL_LOST      = 1'b0;
    BRICKS_CLEARED = 1'b0;
    tick();
  endtask

  task automatic serve_to_play();
    frames(30);
    fire();
    check("to_play", STATE, 2);
  endtask

  initial begin
    int lvl;
    RESET = 1'b1; FRAME_START = 1'b0; BTN_PAUSE = 1'b0;
    BTN_FIRE = 1'b1; BALL_LOST = 1'b0; BRICKS_CLEARED = 1'b0;
    repeat (3) tick();
    check("rst_state", STATE, 0);
    check("rst_lives", LIVES, 0);
    check("rst_level", LEVEL, 0);
    check("rst_hold", BALL_HOLD, 1);
    check("rst_pulses", {START_UPDATE, BALL_RESET, LEVEL_NEXT}, 0);
    RESET = 1'b0;
    repeat (3) tick();
    check("held_fire", STATE, 0);
    BTN_FIRE = 1'b0;
    tick();

    BTN_FIRE = 1'b1;
    tick();
    BTN_FIRE = 1'b0;
    check("start_state", STATE, 1);
    check("start_lives", LIVES, 3);
    check("start_level", LEVEL, 0);
    check("start_br", BALL_RESET, 1);
    check("start_ln", LEVEL_NEXT, 1);
    tick();
    check("start_br_w", {BALL_RESET, LEVEL_NEXT}, 0);
    exp_run = 1;

    frames(10);
    fire();
    check("fire_early", STATE, 1);
    pause();
    check("serve_pause", STATE, 1);
    frames(19);
    fire();
    check("fire_29", STATE, 1);
    frame();
    fire();
    check("fire_30", STATE, 2);
    check("play_hold", BALL_HOLD, 0);
    frames(3);

    exp_run = 0;
    br0 = br_cnt;
    pulse(1, 0);
    check("lost_state", STATE, 4);
    check("lost_lives", LIVES, 2);
    check("lost_hold", BALL_HOLD, 1);
    frames(89);
    check("lost_89", STATE, 4);
    frame();
    check("lost_done", STATE, 1);
    check("lost_br", br_cnt - br0, 1);
    exp_run = 1;
    serve_to_play();

    exp_run = 0;
    pulse(1, 1);
    check("both_state", STATE, 4);
    check("both_lives", LIVES, 1);
    check("both_level", LEVEL, 0);
    frames(90);
    check("both_done", STATE, 1);
    exp_run = 1;
    serve_to_play();

    exp_run = 0;
    pulse(1, 0);
    check("over_state", STATE, 6);
    check("over_lives", LIVES, 0);
    frames(2);

    br0 = br_cnt; ln0 = ln_cnt;
    fire();
    check("restart_state", STATE, 1);
    check("restart_lives", LIVES, 3);
    check("restart_pulses", (br_cnt - br0) * 10 + ln_cnt - ln0, 11);
    exp_run = 1;
    serve_to_play();

    exp_run = 0;
    pulse(0, 1);
    check("clear_state", STATE, 5);
    br0 = br_cnt; ln0 = ln_cnt;
    frames(119);
    check("clear_119", STATE, 5);
    frame();
    check("clear_done", STATE, 1);
    check("clear_level", LEVEL, 1);
    check("clear_ln", ln_cnt - ln0, 1);
    check("clear_br", br_cnt - br0, 1);
    exp_run = 1;

    lvl = 1;
    for (int k = 0; k < 15; k++) begin
      serve_to_play();
      exp_run = 0;
      pulse(0, 1);
      frames(120);
      exp_run = 1;
      lvl = (lvl >= 15) ? 15 : lvl + 1;
      check("level_step", LEVEL, lvl);
    end
    check("level_sat", LEVEL, 15);

    serve_to_play();
    exp_run = 0;
    pause();
    check("pause_state", STATE, 3);
    frames(20);
    pulse(1, 1);
    check("pause_lost", STATE, 3);
    check("pause_lives", LIVES, 3);
    pause();
    check("resume", STATE, 2);
    exp_run = 1;
    frames(3);

    RESET = 1'b1;
    BALL_LOST = 1'b1;
    tick();
    RESET = 1'b0;
    BALL_LOST = 1'b0;
    exp_run = 0;
    check("mid_rst_state", STATE, 0);
    check("mid_rst_lives", LIVES, 0);
    check("mid_rst_hold", BALL_HOLD, 1);
    frames(2);
    check("sb_drain", su_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level game sequencer for breakout: decides each frame whether the update logic runs, and issues its START_UPDATE trigger.
- Tracks game phase (attract, serve, play, pause, life lost, level clear, game over), lives and level.
- Sits between the VGA timing block (frame pulse), the debounced buttons, and the update/ball/brick logic.
- Emits one-cycle control pulses to reposition the ball and advance the level.

Parameters:
INITIAL_LIVES, 3, lives loaded at game start (1..7)
SERVE_ARM_FRAMES, 30, frames in SERVE before FIRE is accepted
LOST_DELAY_FRAMES, 90, frames held in LOST before re-serve
CLEAR_DELAY_FRAMES, 120, frames held in LEVEL_CLEAR before next level
MAX_LEVEL, 15, level counter saturation value

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
FRAME_START  in  1  one-cycle pulse per video frame
BTN_FIRE  in  1  debounced, synchronised fire/serve button (level)
BTN_PAUSE  in  1  debounced, synchronised pause button (level)
BALL_LOST  in  1  one-cycle pulse: ball passed below paddle
BRICKS_CLEARED  in  1  one-cycle pulse: last brick destroyed
START_UPDATE  out  1  one-cycle pulse: run one game-logic update
BALL_HOLD  out  1  high = ball parked on paddle / frozen (all states except PLAY)
BALL_RESET  out  1  one-cycle pulse: move ball to serve position
LEVEL_NEXT  out  1  one-cycle pulse: reload brick field for next level
LIVES  out  3  remaining lives
LEVEL  out  4  current level, 0-based
STATE  out  3  encoded state (for HUD/debug)

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RESET.
- Reset values: STATE=ATTRACT, LIVES=0, LEVEL=0, all pulse outputs 0, BALL_HOLD=1, frame timer 0, edge-detect registers cleared.
- RESET asserted mid-game overrides every transition in the same edge.
- State encoding: ATTRACT=0, SERVE=1, PLAY=2, PAUSED=3, LOST=4, LEVEL_CLEAR=5, GAME_OVER=6.
- Button handling: FIRE and PAUSE act on rising edges only, using a registered previous value.
  - A button held through reset does not produce an edge on release of reset.
- Frame timer: 8-bit.
  - Cleared on every state entry.
  - Increments on FRAME_START, saturating at 255.
  - Delay parameters must be ≤255.
- START_UPDATE:
  - Registered pulse in the cycle after a FRAME_START sampled while STATE is SERVE or PLAY.
  - Never issued in other states.
  - Exactly one pulse per frame.
- ATTRACT / GAME_OVER: FIRE edge goes to SERVE with:
  - LIVES ← INITIAL_LIVES;
  - LEVEL ← 0;
  - BALL_RESET and LEVEL_NEXT pulsed in the same cycle as the state change.
- SERVE:
  - FIRE edge with timer ≥ SERVE_ARM_FRAMES goes to PLAY.
  - FIRE edges while the timer is below SERVE_ARM_FRAMES are ignored.
  - PAUSE is ignored.
- PLAY: priority when events coincide is BALL_LOST > BRICKS_CLEARED > PAUSE edge.
  - BALL_LOST with LIVES=1: LIVES ← 0, go to GAME_OVER.
  - BALL_LOST with LIVES>1: LIVES−1, go to LOST.
  - BRICKS_CLEARED goes to LEVEL_CLEAR.
  - PAUSE edge goes to PAUSED.
- PAUSED:
  - PAUSE edge returns to PLAY, with the timer cleared.
  - BALL_LOST and BRICKS_CLEARED are ignored (the logic is frozen).
- LOST: when timer reaches LOST_DELAY_FRAMES, pulse BALL_RESET and go to SERVE.
- LEVEL_CLEAR: when timer reaches CLEAR_DELAY_FRAMES:
  - pulse BALL_RESET and LEVEL_NEXT;
  - LEVEL ← min(LEVEL+1, MAX_LEVEL);
  - go to SERVE.
- BALL_LOST / BRICKS_CLEARED received in states other than PLAY are dropped.
- All outputs are registered; pulse outputs are high for exactly one cycle.
- LIVES never underflows.

Test Plan:
- Reset, then FIRE edge → STATE=1, LIVES=3, LEVEL=0, and BALL_RESET plus LEVEL_NEXT each high for 1 cycle; 10 FRAME_START pulses → 10 START_UPDATE pulses, each 1 cycle after its frame pulse.
- In SERVE: FIRE at frame 10 → stays SERVE; FIRE at frame 30 → STATE=2 and BALL_HOLD=0.
- In PLAY with LIVES=3: BALL_LOST → STATE=4, LIVES=2, no START_UPDATE for 90 frames, then BALL_RESET pulse and STATE=1. Repeat until LIVES=1; next BALL_LOST → STATE=6 and LIVES=0.
- In PLAY: BALL_LOST and BRICKS_CLEARED in the same cycle → STATE=4 and LIVES decrements; LEVEL unchanged.
- In PLAY: BRICKS_CLEARED → STATE=5; after 120 frames, LEVEL_NEXT pulse and LEVEL=1. Force LEVEL=15 and clear again → LEVEL stays 15.
- In PLAY: PAUSE edge → STATE=3, zero START_UPDATE across 20 frames, and BALL_LOST ignored; second PAUSE edge → STATE=2. RESET asserted in PLAY → ATTRACT, LIVES=0, BALL_HOLD=1 on the next edge.
